// File: rtl/regdst_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regdst_pipe_pkg
// Description : Shared CPU definitions for destination-register selection.
//               Provides default address width and link register, named
//               source-select codes and a popcount helper.
// Revision    : 1.0 - initial release
// ============================================================================
package regdst_pipe_pkg;

    localparam int AW_DEFAULT       = 5;
    localparam int LINK_REG_DEFAULT = 31;
    localparam int NSRC_DEFAULT     = 2;

    // Source-select codes. Any code >= NSRC selects the link register.
    localparam int SEL_RD   = 0;
    localparam int SEL_RT   = 1;
    localparam int SEL_LINK = NSRC_DEFAULT;

    // Population count of up to eight write-enable bits.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regdst_stage.sv
`default_nettype none
// ============================================================================
// Module      : regdst_stage
// Description : One pipeline slot holding a destination address and its
//               write-enable. Bubble has priority over load; otherwise the
//               slot holds.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               i_load          - capture i_dest/i_we
//               i_bubble        - clear the slot (dest 0, we 0)
//               i_dest, i_we    - incoming address / write-enable
//               o_dest, o_we    - registered address / write-enable
// Revision    : 1.0 - initial release
// ============================================================================
module regdst_stage #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_bubble,
    input  logic [AW-1:0] i_dest,
    input  logic          i_we,
    output logic [AW-1:0] o_dest,
    output logic          o_we
);

    logic [AW-1:0] r_dest;
    logic          r_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dest <= '0;
            r_we   <= 1'b0;
        end else if (i_bubble) begin
            r_dest <= '0;
            r_we   <= 1'b0;
        end else if (i_load) begin
            r_dest <= i_dest;
            r_we   <= i_we;
        end
    end

    assign o_dest = r_dest;
    assign o_we   = r_we;

endmodule
`default_nettype wire

// File: rtl/regdst_pipe.sv
`default_nettype none
// ============================================================================
// Module      : regdst_pipe
// Description : Destination-register select mux followed by a DEPTH-stage
//               dest/we pipeline with stall and flush. Writes to register 0
//               are suppressed. Provides per-stage RAW hazard flags for two
//               read ports and a registered count of in-flight writes.
// Ports       : clk, rst_n           - clock, asynchronous active-low reset
//               in_valid, in_we      - instruction present / writes regfile
//               src_addr, sel        - candidate fields and field select
//               stall, flush         - freeze pipe / bubble the entry stage
//               rs_addr, rt_addr     - decode-stage read addresses
//               stage_dest, stage_we - per-stage registered dest / we
//               wb_dest, wb_we       - last stage (write-back) dest / we
//               haz_rs, haz_rt       - per-stage RAW match flags
//               inflight             - number of set stage_we bits
// Revision    : 1.0 - initial release
// ============================================================================
module regdst_pipe
    import regdst_pipe_pkg::*;
#(
    parameter int AW       = AW_DEFAULT,
    parameter int NSRC     = NSRC_DEFAULT,
    parameter int DEPTH    = 3,             // legal range 1..8
    parameter int LINK_REG = LINK_REG_DEFAULT,
    localparam int SW      = ($clog2(NSRC + 1) < 1) ? 1 : $clog2(NSRC + 1),
    localparam int IW      = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                in_we,
    input  logic [NSRC*AW-1:0]  src_addr,
    input  logic [SW-1:0]       sel,
    input  logic                stall,
    input  logic                flush,
    input  logic [AW-1:0]       rs_addr,
    input  logic [AW-1:0]       rt_addr,
    output logic [DEPTH*AW-1:0] stage_dest,
    output logic [DEPTH-1:0]    stage_we,
    output logic [AW-1:0]       wb_dest,
    output logic                wb_we,
    output logic [DEPTH-1:0]    haz_rs,
    output logic [DEPTH-1:0]    haz_rt,
    output logic [IW-1:0]       inflight
);

    localparam logic [AW-1:0] c_link_addr = AW'(LINK_REG);

    logic [AW-1:0]    w_sel_addr;
    logic             w_eff_we;
    logic [DEPTH-1:0] w_next_we;
    logic [7:0]       w_we_ext;
    logic [IW-1:0]    r_inflight;

    // ------------------------------------------------------------------
    // Source selection: out-of-range select codes fall through to link.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_addr = c_link_addr;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(sel) == i) begin
                w_sel_addr = src_addr[i*AW +: AW];
            end
        end
    end

    // Register 0 is hard-wired; its address is still carried but never
    // marked as written.
    assign w_eff_we = in_valid && in_we && (w_sel_addr != '0);

    // ------------------------------------------------------------------
    // Pipeline stages
    // ------------------------------------------------------------------
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [AW-1:0] w_d_dest;
        logic          w_d_we;
        logic          w_bubble;

        if (k == 0) begin : g_head
            assign w_d_dest = w_sel_addr;
            assign w_d_we   = w_eff_we;
            assign w_bubble = flush;
        end else begin : g_body
            assign w_d_dest = stage_dest[(k-1)*AW +: AW];
            assign w_d_we   = stage_we[k-1];
            assign w_bubble = 1'b0;
        end

        regdst_stage #(
            .AW (AW)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_load   (~stall),
            .i_bubble (w_bubble),
            .i_dest   (w_d_dest),
            .i_we     (w_d_we),
            .o_dest   (stage_dest[k*AW +: AW]),
            .o_we     (stage_we[k])
        );

        // RAW hazard flags; register 0 never conflicts.
        assign haz_rs[k] = stage_we[k] && (stage_dest[k*AW +: AW] == rs_addr)
                           && (rs_addr != '0);
        assign haz_rt[k] = stage_we[k] && (stage_dest[k*AW +: AW] == rt_addr)
                           && (rt_addr != '0);
    end

    assign wb_dest = stage_dest[(DEPTH-1)*AW +: AW];
    assign wb_we   = stage_we[DEPTH-1];

    // ------------------------------------------------------------------
    // In-flight count: popcount of the write-enables the stages are about
    // to load, so the registered count tracks stage_we on every edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_we    = '0;
        w_next_we[0] = flush ? 1'b0 : (stall ? stage_we[0] : w_eff_we);
        for (int k = 1; k < DEPTH; k++) begin
            w_next_we[k] = stall ? stage_we[k] : stage_we[k-1];
        end
    end

    always_comb begin
        w_we_ext              = '0;
        w_we_ext[DEPTH-1:0]   = w_next_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= IW'(popcount8(w_we_ext));
        end
    end

    assign inflight = r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_regdst_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_regdst_pipe
// Description : Directed self-checking bench for regdst_pipe (DEPTH=3,
//               NSRC=2, AW=5, LINK_REG=31).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regdst_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_we;
    logic [9:0]  src_addr;
    logic [1:0]  sel;
    logic        stall;
    logic        flush;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [14:0] stage_dest;
    logic [2:0]  stage_we;
    logic [4:0]  wb_dest;
    logic        wb_we;
    logic [2:0]  haz_rs;
    logic [2:0]  haz_rt;
    logic [1:0]  inflight;

    int n_chk;
    int n_pass;

    regdst_pipe #(
        .AW       (5),
        .NSRC     (2),
        .DEPTH    (3),
        .LINK_REG (31)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_we      (in_we),
        .src_addr   (src_addr),
        .sel        (sel),
        .stall      (stall),
        .flush      (flush),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .stage_dest (stage_dest),
        .stage_we   (stage_we),
        .wb_dest    (wb_dest),
        .wb_we      (wb_we),
        .haz_rs     (haz_rs),
        .haz_rt     (haz_rt),
        .inflight   (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input logic [4:0] rd, input logic [4:0] rt);
        src_addr = {rt, rd};
    endtask

    // Push one unstalled instruction selecting the rd field.
    task automatic push(input logic [4:0] rd, input logic we);
        sel      = 2'd0;
        in_valid = 1'b1;
        in_we    = we;
        set_src(rd, 5'd0);
        step();
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_we    = 1'b1;
        sel      = 2'd0;
        stall    = 1'b0;
        flush    = 1'b0;
        rs_addr  = 5'd12;
        rt_addr  = 5'd8;
        set_src(5'd12, 5'd8);

        // ---------------- reset held with live inputs ----------------
        #1;
        chk("rst_we",       32'(stage_we), 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);
        for (int i = 0; i < 2; i++) begin
            sel = 2'(i + 1);
            step();
            chk("rst_hold_we",  32'(stage_we), 32'h0);
            chk("rst_hold_inf", 32'(inflight), 32'h0);
            chk("rst_hold_haz", 32'({haz_rs, haz_rt}), 32'h0);
        end
        rst_n = 1'b1;

        // ---------------- select: rd, rt, link, link ----------------
        sel = 2'd0;
        step();
        chk("sel0_s0",  32'(stage_dest[4:0]), 32'd12);
        chk("sel0_we",  32'(stage_we[0]), 32'd1);
        chk("sel0_inf", 32'(inflight), 32'd1);
        sel = 2'd1;
        step();
        chk("sel1_s0",  32'(stage_dest[4:0]), 32'd8);
        chk("sel1_inf", 32'(inflight), 32'd2);
        sel = 2'd2;
        step();
        chk("sel2_s0",  32'(stage_dest[4:0]), 32'd31);
        chk("wb_e3",    32'(wb_dest), 32'd12);
        chk("wb_we_e3", 32'(wb_we), 32'd1);
        chk("sel2_inf", 32'(inflight), 32'd3);
        chk("haz_rs_e3", 32'(haz_rs), 32'b100);
        chk("haz_rt_e3", 32'(haz_rt), 32'b010);
        sel = 2'd3;
        step();
        chk("sel3_s0", 32'(stage_dest[4:0]), 32'd31);
        chk("wb_e4",   32'(wb_dest), 32'd8);
        in_valid = 1'b0;
        step();
        chk("wb_e5",   32'(wb_dest), 32'd31);
        chk("inf_e5",  32'(inflight), 32'd2);
        step();
        chk("wb_e6",   32'(wb_dest), 32'd31);
        chk("inf_e6",  32'(inflight), 32'd1);
        step();
        chk("inf_e7",  32'(inflight), 32'd0);

        // ---------------- zero register ----------------
        push(5'd7, 1'b1);
        chk("z_pre_inf", 32'(inflight), 32'd1);
        rs_addr = 5'd0;
        push(5'd0, 1'b1);
        chk("z_dest0", 32'(stage_dest[4:0]), 32'd0);
        chk("z_we0",   32'(stage_we[0]), 32'd0);
        chk("z_inf",   32'(inflight), 32'd1);
        chk("z_haz",   32'(haz_rs), 32'd0);
        rs_addr = 5'd7;
        #1;
        chk("z_haz7",  32'(haz_rs), 32'b010);

        // ---------------- stall / flush ----------------
        push(5'd6, 1'b1);
        push(5'd5, 1'b1);
        push(5'd4, 1'b1);
        stall = 1'b1;
        set_src(5'd9, 5'd9);
        step();
        step();
        chk("stall_dest", 32'(stage_dest), 32'({5'd6, 5'd5, 5'd4}));
        chk("stall_we",   32'(stage_we), 32'b111);
        chk("stall_inf",  32'(inflight), 32'd3);
        flush = 1'b1;
        step();
        chk("sf_dest", 32'(stage_dest), 32'({5'd6, 5'd5, 5'd0}));
        chk("sf_we",   32'(stage_we), 32'b110);
        chk("sf_inf",  32'(inflight), 32'd2);
        stall = 1'b0;
        step();
        chk("fl_dest", 32'(stage_dest), 32'({5'd5, 5'd0, 5'd0}));
        chk("fl_we",   32'(stage_we), 32'b100);
        chk("fl_inf",  32'(inflight), 32'd1);
        flush = 1'b0;

        // ---------------- hazard flags ----------------
        push(5'd3, 1'b1);
        push(5'd9, 1'b1);
        push(5'd9, 1'b1);
        stall   = 1'b1;
        rs_addr = 5'd9;
        rt_addr = 5'd3;
        #1;
        chk("haz_rs_a", 32'(haz_rs), 32'b011);
        chk("haz_rt_a", 32'(haz_rt), 32'b100);
        stall = 1'b0;
        push(5'd3, 1'b1);
        push(5'd9, 1'b0);
        push(5'd9, 1'b1);
        stall = 1'b1;
        #1;
        chk("haz_we_b", 32'(stage_we), 32'b101);
        chk("haz_rs_b", 32'(haz_rs), 32'b001);
        chk("haz_rt_b", 32'(haz_rt), 32'b100);
        stall = 1'b0;

        // ---------------- async reset mid-stream ----------------
        push(5'd1, 1'b1);
        push(5'd2, 1'b1);
        push(5'd3, 1'b1);
        chk("ar_pre_inf", 32'(inflight), 32'd3);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_we",   32'(stage_we), 32'h0);
        chk("ar_dest", 32'(stage_dest), 32'h0);
        chk("ar_inf",  32'(inflight), 32'h0);
        chk("ar_haz",  32'({haz_rs, haz_rt}), 32'h0);
        rst_n = 1'b1;
        push(5'd17, 1'b1);
        in_valid = 1'b0;
        chk("ar_e1_wb", 32'(wb_we), 32'd0);
        step();
        chk("ar_e2_wb", 32'(wb_we), 32'd0);
        step();
        chk("ar_e3_we",   32'(wb_we), 32'd1);
        chk("ar_e3_dest", 32'(wb_dest), 32'd17);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
